display_pixel_serializer: RTL and testbench

- Upstream feeder of the display capture stage. Accepts 24-bit RGB pixels over a valid/ready interface and buffers them in a small FIFO.
- Emits each pixel as three consecutive bytes (red, green, blue) on FrameIn, with CSDisplay high for exactly those three cycles.
- Frames are started by a FrameStart pulse and end after PIXELS_PER_FRAME pixels, flagged by a FrameDone pulse.
- The downstream stage counts bytes modulo 3, so pixel triplets are never broken.

---
 rtl/display_pixel_serializer.sv | 166 ++++++++++++++++
 tb/tb_display_pixel_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_pixel_serializer.sv
// Pixel FIFO plus byte serializer feeding the display capture stage.
// Each buffered 24-bit pixel goes out as an unbroken R,G,B byte triplet.
//
// state | meaning
// IDLE  | no frame in progress, bus idle
// ARMED | frame open, waiting for a pixel in the FIFO
// S_R   | red byte on FrameIn
// S_G   | green byte on FrameIn
// S_B   | blue byte on FrameIn, last cycle of the triplet
module display_pixel_serializer #(
   parameter int PIXELS_PER_FRAME = 200,
   parameter int FIFO_DEPTH       = 4,
   parameter int CNT_W            = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [23:0]      PixelIn,
   input  logic             PixelValid,
   output logic             PixelReady,
   input  logic             FrameStart,
   output logic [7:0]       FrameIn,
   output logic             CSDisplay,
   output logic             Busy,
   output logic             FrameDone,
   output logic [CNT_W-1:0] PixelCount
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, ARMED, S_R, S_G, S_B} state_t;

   state_t           state_q;
   logic [7:0]       frame_in_q;
   logic             cs_q;
   logic             done_q;
   logic [CNT_W-1:0] pix_cnt_q;
   logic [7:0]       g_q;
   logic [7:0]       b_q;

   logic [23:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;

   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             last_pix;
   logic [23:0]      pop_data;

   assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = PixelValid && !fifo_full;
   assign last_pix   = (pix_cnt_q == CNT_W'(PIXELS_PER_FRAME - 1));
   assign pop_data   = mem_q[rd_ptr_q];

   // Pops line up exactly with the FSM edges that load a new triplet.
   assign pop = !fifo_empty &&
                ((state_q == ARMED) || ((state_q == S_B) && !last_pix));

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= PixelIn;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= IDLE;
         frame_in_q <= 8'h00;
         cs_q       <= 1'b0;
         done_q     <= 1'b0;
         pix_cnt_q  <= '0;
         g_q        <= 8'h00;
         b_q        <= 8'h00;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cs_q <= 1'b0;
               if (FrameStart) begin
                  state_q   <= ARMED;
                  pix_cnt_q <= '0;
               end
            end
            ARMED: begin
               if (!fifo_empty) begin
                  state_q    <= S_R;
                  frame_in_q <= pop_data[23:16];
                  g_q        <= pop_data[15:8];
                  b_q        <= pop_data[7:0];
                  cs_q       <= 1'b1;
               end else begin
                  cs_q <= 1'b0;
               end
            end
            S_R: begin
               state_q    <= S_G;
               frame_in_q <= g_q;
               cs_q       <= 1'b1;
            end
            S_G: begin
               state_q    <= S_B;
               frame_in_q <= b_q;
               cs_q       <= 1'b1;
            end
            S_B: begin
               pix_cnt_q <= pix_cnt_q + 1'b1;
               if (last_pix) begin
                  state_q <= IDLE;
                  cs_q    <= 1'b0;
                  done_q  <= 1'b1;
               end else if (!fifo_empty) begin
                  state_q    <= S_R;
                  frame_in_q <= pop_data[23:16];
                  g_q        <= pop_data[15:8];
                  b_q        <= pop_data[7:0];
                  cs_q       <= 1'b1;
               end else begin
                  state_q <= ARMED;
                  cs_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_q    <= 1'b0;
            end
         endcase
      end
   end

   assign PixelReady = !fifo_full;
   assign FrameIn    = frame_in_q;
   assign CSDisplay  = cs_q;
   assign Busy       = (state_q != IDLE);
   assign FrameDone  = done_q;
   assign PixelCount = pix_cnt_q;

endmodule

// File: tb/tb_display_pixel_serializer.sv
// Directed bench for display_pixel_serializer with a 3-pixel frame.
// Inputs change and outputs are checked on the falling clock edge.
module tb_display_pixel_serializer;

   localparam int PPF = 3;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [23:0] PixelIn = 24'h0;
   logic        PixelValid = 1'b0;
   logic        PixelReady;
   logic        FrameStart = 1'b0;
   logic [7:0]  FrameIn;
   logic        CSDisplay;
   logic        Busy;
   logic        FrameDone;
   logic [7:0]  PixelCount;

   display_pixel_serializer #(
      .PIXELS_PER_FRAME(PPF),
      .FIFO_DEPTH(4),
      .CNT_W(8)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .PixelIn(PixelIn),
      .PixelValid(PixelValid),
      .PixelReady(PixelReady),
      .FrameStart(FrameStart),
      .FrameIn(FrameIn),
      .CSDisplay(CSDisplay),
      .Busy(Busy),
      .FrameDone(FrameDone),
      .PixelCount(PixelCount)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Byte capture and triplet-integrity watch, sampled mid-cycle.
   logic [7:0]  byte_q[$];
   logic [23:0] exp_px[$];
   int          run_len = 0;
   int          last_run = 0;

   always @(negedge clock) begin
      #1;
      if (!resetn) begin
         run_len = 0;
      end else if (CSDisplay) begin
         byte_q.push_back(FrameIn);
         run_len++;
      end else if (run_len != 0) begin
         check("run_mod3", run_len % 3, 0);
         last_run = run_len;
         run_len  = 0;
      end
   end

   task automatic push1(input logic [23:0] p);
      PixelIn    = p;
      PixelValid = 1'b1;
      @(negedge clock);
      PixelValid = 1'b0;
   endtask

   task automatic pulse_start();
      FrameStart = 1'b1;
      @(negedge clock);
      FrameStart = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int guard = 0;
      while (!FrameDone && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      check({tag, "_done"}, FrameDone, 1);
      check({tag, "_busy"}, Busy, 0);
      check({tag, "_cs"}, CSDisplay, 0);
      @(negedge clock);
      check({tag, "_done_pulse"}, FrameDone, 0);
   endtask

   task automatic wait_cs(input string tag);
      int guard = 0;
      while (!CSDisplay && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      check({tag, "_cs_rise"}, CSDisplay, 1);
   endtask

   task automatic check_bytes(input string tag);
      logic [23:0] got;
      check({tag, "_len"}, byte_q.size(), exp_px.size() * 3);
      for (int i = 0; i < exp_px.size(); i++) begin
         if (byte_q.size() >= 3 * i + 3) begin
            got = {byte_q[3*i], byte_q[3*i+1], byte_q[3*i+2]};
         end else begin
            got = 24'hxxxxxx;
         end
         check({tag, "_px"}, got, exp_px[i]);
      end
   endtask

   initial begin
      logic [23:0] bp [6];
      logic [23:0] sp [3];
      int          idx;
      int          guard;
      logic        will_acc;

      // Reset with PixelValid high: nothing may enter the FIFO.
      PixelValid = 1'b1;
      PixelIn    = 24'hABCDEF;
      repeat (3) @(negedge clock);
      check("rst_cs", CSDisplay, 0);
      check("rst_framein", FrameIn, 8'h00);
      check("rst_busy", Busy, 0);
      check("rst_done", FrameDone, 0);
      check("rst_count", PixelCount, 0);
      check("rst_ready", PixelReady, 1);
      PixelValid = 1'b0;
      resetn     = 1'b1;
      @(negedge clock);
      check("post_rst_ready", PixelReady, 1);
      pulse_start();
      check("post_rst_armed", Busy, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("post_rst_empty", CSDisplay, 0);
      end
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      check("rst2_idle", Busy, 0);

      // Back-to-back frame from a preloaded FIFO.
      byte_q.delete();
      exp_px = '{24'hFF8040, 24'h102030, 24'h0A0B0C};
      push1(24'hFF8040);
      push1(24'h102030);
      push1(24'h0A0B0C);
      pulse_start();
      wait_done("b2b");
      check("b2b_run", last_run, 9);
      check("b2b_count", PixelCount, 3);
      check_bytes("b2b");
      check("b2b_word", (byte_q.size() >= 3) ? {8'h00, byte_q[0], byte_q[1], byte_q[2]} : 32'hxxxxxxxx,
            32'h00FF8040);

      // Starvation: one pixel every 7 cycles into an empty FIFO.
      byte_q.delete();
      sp = '{24'h112233, 24'h445566, 24'h778899};
      pulse_start();
      check("stv_clear", PixelCount, 0);
      repeat (3) @(negedge clock);
      check("stv_idle_bus", CSDisplay, 0);
      for (int k = 0; k < 3; k++) begin
         PixelIn    = sp[k];
         PixelValid = 1'b1;
         @(negedge clock);
         PixelValid = 1'b0;
         check("stv_lat_cs0", CSDisplay, 0);
         @(negedge clock);
         check("stv_r_cs", CSDisplay, 1);
         check("stv_r", FrameIn, sp[k][23:16]);
         @(negedge clock);
         check("stv_g", FrameIn, sp[k][15:8]);
         @(negedge clock);
         check("stv_b", FrameIn, sp[k][7:0]);
         @(negedge clock);
         check("stv_gap", CSDisplay, 0);
         check("stv_count", PixelCount, k + 1);
         if (k == 2) check("stv_done", FrameDone, 1);
         else check("stv_busy", Busy, 1);
         @(negedge clock);
         check("stv_run", last_run, 3);
         @(negedge clock);
      end

      // Backpressure: six pushes in IDLE, only four fit.
      byte_q.delete();
      bp = '{24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 24'hD1D2D3, 24'hE1E2E3, 24'hF1F2F3};
      for (int i = 0; i < 6; i++) begin
         PixelIn    = bp[i];
         PixelValid = 1'b1;
         check("bp_ready", PixelReady, (i < 4) ? 1 : 0);
         @(negedge clock);
      end
      idx        = 4;
      PixelIn    = bp[4];
      FrameStart = 1'b1;
      guard      = 0;
      while (idx < 6 && guard < 60) begin
         will_acc = PixelReady;
         @(negedge clock);
         FrameStart = 1'b0;
         guard++;
         if (will_acc) begin
            idx++;
            if (idx < 6) PixelIn = bp[idx];
         end
      end
      PixelValid = 1'b0;
      FrameStart = 1'b0;
      check("bp_accepted", idx, 6);
      wait_done("bp1");
      pulse_start();
      wait_done("bp2");
      exp_px = '{bp[0], bp[1], bp[2], bp[3], bp[4], bp[5]};
      check_bytes("bp");

      // FrameStart while busy is ignored.
      byte_q.delete();
      exp_px = '{24'h010203, 24'h040506, 24'h070809};
      push1(24'h010203);
      push1(24'h040506);
      push1(24'h070809);
      pulse_start();
      wait_cs("fb");
      @(negedge clock);
      FrameStart = 1'b1;
      @(negedge clock);
      FrameStart = 1'b0;
      check("fb_cs1", CSDisplay, 1);
      check("fb_b1", FrameIn, 8'h03);
      check("fb_cnt0", PixelCount, 0);
      @(negedge clock);
      check("fb_r2", FrameIn, 8'h04);
      check("fb_cnt1", PixelCount, 1);
      @(negedge clock);
      FrameStart = 1'b1;
      @(negedge clock);
      FrameStart = 1'b0;
      check("fb_b2", FrameIn, 8'h06);
      check("fb_cnt1_hold", PixelCount, 1);
      wait_done("fb");
      check("fb_count", PixelCount, 3);
      check_bytes("fb");

      // Reset in S_G aborts the triplet and empties the FIFO.
      push1(24'h5A5B5C);
      push1(24'h6A6B6C);
      pulse_start();
      wait_cs("mr");
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      check("mr_cs", CSDisplay, 0);
      check("mr_busy", Busy, 0);
      check("mr_framein", FrameIn, 8'h00);
      check("mr_count", PixelCount, 0);
      resetn = 1'b1;
      byte_q.delete();
      pulse_start();
      repeat (4) @(negedge clock);
      check("mr_fifo_empty", CSDisplay, 0);
      check("mr_armed", Busy, 1);
      exp_px = '{24'h123456, 24'h789ABC, 24'hDEF012};
      push1(24'h123456);
      push1(24'h789ABC);
      push1(24'hDEF012);
      wait_done("mr");
      check_bytes("mr");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
